map_write_scheduler: RTL and testbench
======================================

Name: map_write_scheduler

Overview:
- Collects map-cell tile updates from two requesters: port 0 (bus/CPU register writes) and port 1 (game-logic engine, e.g. bomb/explosion updates).
- Arbitrates the requesters round-robin into a small FIFO.
- Commits queued updates to the tile-map RAM write port only while the display is in vertical blanking, so a frame never shows a half-updated map.
- Sits between the bus slave / game logic and the map RAM inside the display subsystem.

Parameters:
- FIFO_DEPTH, 16, number of queued updates (power of two, >= 2).
- MAP_CELLS, 1200, valid cell count (40 x 30 grid); addresses >= MAP_CELLS are rejected.

Ports:
- clk  in  1  system clock (50 MHz pixel-domain clock).
- reset  in  1  asynchronous, active-high reset.
- vblank  in  1  high while the display counter is outside the active region vertically (vcount >= 480).
- req0_valid  in  1  port 0 update request.
- req0_addr  in  11  port 0 cell address (row*40 + col).
- req0_tile  in  4  port 0 tile code (0 background, 1 stone, 2 box, others reserved but stored).
- req0_ready  out  1  port 0 accepted this cycle.
- req1_valid, req1_addr, req1_tile, req1_ready  same as port 0, for port 1.
- map_write  out  1  map RAM write enable.
- map_write_addr  out  11  map RAM write address.
- map_write_data  out  8  map RAM write data; {4'd0, tile}.
- fifo_count  out  5  entries currently queued (width = clog2(FIFO_DEPTH)+1).
- busy  out  1  FIFO non-empty or a write is in flight.
- err_range  out  1  sticky; a request with addr >= MAP_CELLS was seen.
- err_clear  in  1  clears err_range.

Behaviour:
- Reset (async, active-high) values:
  - map_write=0, map_write_addr=0, map_write_data=0.
  - fifo_count=0, busy=0, err_range=0.
  - Round-robin pointer favours port 0.
  - FSM = IDLE.
  - FIFO contents are discarded; a reset mid-drain drops every queued entry, and no write is issued after reset asserts.
- Accept handshake:
  - reqN_ready is combinational. It is 1 when the port is granted this cycle and the FIFO is not full, or when the FIFO would be freed by a pop in the same cycle.
  - A transfer occurs when valid && ready.
  - At most one push per cycle.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both valid: the port not granted last is granted.
  - The pointer updates only on an actual transfer.
- Range check:
  - A granted request with addr >= MAP_CELLS is consumed (ready=1) but not queued.
  - It sets err_range on the next edge.
  - err_clear has priority below a same-cycle set, i.e. the set wins.
- FSM:
  - IDLE: FIFO empty. Goes to PENDING on the first push.
  - PENDING: FIFO non-empty, vblank=0. Goes to DRAIN when vblank=1.
  - DRAIN: while vblank=1 and FIFO non-empty, pop the head every cycle.
    - Returns to PENDING when vblank falls with entries remaining.
    - Returns to IDLE when the FIFO empties.
- Write timing:
  - Registered output, latency 1: an entry popped at edge k drives map_write=1 with its addr/data during cycle k+1.
  - map_write is high for exactly one cycle per entry.
  - The last pop may occur in the final vblank cycle. Its write lands one cycle after vblank falls; this is legal because the RAM is dual-port and the line is not yet displayed.
- Simultaneous push and pop in the same cycle: fifo_count is unchanged. Push into a full FIFO is legal only when a pop happens the same cycle.
- Ordering: entries are committed strictly in acceptance order. Two updates to the same cell commit both; the later one wins.
- Pointer wrap: FIFO pointers are clog2(FIFO_DEPTH) bits plus a wrap bit. Full means the indices are equal and the wrap bits differ.
- busy = (fifo_count != 0) || map_write.

Optional Feature:
- Macro: MAP_WRITE_COALESCE_EN.
- Defined:
  - If an accepted request's addr equals the FIFO tail entry's addr, and that entry is not being popped in the same cycle, overwrite the tail tile in place.
  - There is no push and fifo_count is unchanged.
  - ready is still 1 even when the FIFO is full.
- Not defined: every accepted in-range request is pushed.

Decomposition:
- Package map_sched_pkg holds:
  - typedef map_req_t, a packed struct {logic [10:0] addr; logic [3:0] tile;}.
  - enum tile_t {TILE_BG=0, TILE_STONE=1, TILE_BOX=2}.
  - Localparams MAP_COLS=40, MAP_ROWS=30.
  - FSM state enum {IDLE, PENDING, DRAIN}.
- One sub-module, map_req_fifo: a synchronous FIFO of map_req_t with push/pop/full/empty/count and tail-entry read/overwrite. Arbiter and FSM stay in the top.

Test Plan:
- vblank=0, push port0 {addr=41, tile=2} -> ready=1; fifo_count=1; no map_write. Raise vblank -> map_write=1, addr=41, data=8'h02 exactly one cycle after the pop; fifo_count=0; busy=0 afterwards.
- Both ports valid for 4 cycles (port0 addr 10..13, port1 addr 20..23), vblank=0 -> accept order 10,20,11,21,12,22,13,23. Drained writes appear in the same order.
- Fill 16 entries, vblank=0, hold req0_valid -> req0_ready=0. Set vblank for 3 cycles -> 3 writes; new pushes are accepted as space frees; fifo_count never exceeds 16.
- Request addr=1200 -> ready=1, not queued, err_range=1. Pulse err_clear -> err_range=0.
- 10 queued, vblank high for 4 cycles then low -> 4 writes, FSM in PENDING with fifo_count=6. Assert reset mid-drain -> map_write=0 immediately, fifo_count=0.
- With MAP_WRITE_COALESCE_EN: push {5,1} then {5,2} -> fifo_count=1; drain writes data 8'h02 once. Without the macro: two writes, 8'h01 then 8'h02.

Source files
------------

// File: rtl/map_sched_pkg.sv
// Shared types for the map write scheduler: queued update record, tile codes,
// map geometry and scheduler FSM states.
package map_sched_pkg;

  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;

  typedef struct packed {
    logic [10:0] addr;
    logic [3:0]  tile;
  } map_req_t;

  typedef enum logic [3:0] {
    TILE_BG    = 4'd0,
    TILE_STONE = 4'd1,
    TILE_BOX   = 4'd2
  } tile_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/map_req_fifo.sv
// Synchronous FIFO of map updates with a wrap-bit pointer scheme and an
// in-place tile overwrite port for the most recently queued entry.
module map_req_fifo
  import map_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  map_req_t                 push_data,
  input  logic                     pop,
  output map_req_t                 head,
  input  logic                     tail_wr,
  input  logic [3:0]               tail_tile,
  output map_req_t                 tail,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  map_req_t    mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, tail_ptr;

  assign tail_ptr = wr_ptr - ONE;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign tail     = mem[tail_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // Storage needs no reset: pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= push_data;
    else if (tail_wr)
      mem[tail_ptr[AW-1:0]].tile <= tail_tile;
  end

endmodule

// File: rtl/map_write_scheduler.sv
// Round-robin collects tile updates from two ports and commits them to map RAM
// only during vblank. Optional macro MAP_WRITE_COALESCE_EN merges tail repeats.
module map_write_scheduler
  import map_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAP_CELLS  = 1200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vblank,
  input  logic                          req0_valid,
  input  logic [10:0]                   req0_addr,
  input  logic [3:0]                    req0_tile,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [10:0]                   req1_addr,
  input  logic [3:0]                    req1_tile,
  output logic                          req1_ready,
  output logic                          map_write,
  output logic [10:0]                   map_write_addr,
  output logic [7:0]                    map_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          err_range,
  input  logic                          err_clear
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [11:0] CELLS = 12'(MAP_CELLS);

  sched_state_t state, state_next;
  logic     last_gnt;  // 1 = port 1 was granted last, so port 0 wins a tie
  logic     gnt0, gnt1, in_range, accept, push, pop, coalesce, drained;
  logic     full, empty;
  map_req_t sel, head, tail;

  assign gnt1     = req1_valid && (!req0_valid || !last_gnt);
  assign gnt0     = req0_valid && !gnt1;
  assign sel      = gnt1 ? {req1_addr, req1_tile} : {req0_addr, req0_tile};
  assign in_range = ({1'b0, sel.addr} < CELLS);
  assign pop      = vblank && !empty;

`ifdef MAP_WRITE_COALESCE_EN
  // A tail that is also the head being popped this cycle cannot be merged into.
  assign coalesce = in_range && !empty && (tail.addr == sel.addr) &&
                    !(pop && fifo_count == CW'(1));
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign coalesce    = 1'b0;
`endif

  assign accept     = (gnt0 || gnt1) && (!in_range || coalesce || !full || pop);
  assign req0_ready = gnt0 && accept;
  assign req1_ready = gnt1 && accept;
  assign push       = accept && in_range && !coalesce;
  assign drained    = pop && !push && (fifo_count == CW'(1));
  assign busy       = (fifo_count != '0) || map_write;

  map_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (sel),
    .pop       (pop),
    .head      (head),
    .tail_wr   (accept && coalesce),
    .tail_tile (sel.tile),
    .tail      (tail),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (push) state_next = PENDING;
      PENDING: if (drained) state_next = IDLE;
               else if (vblank) state_next = DRAIN;
      DRAIN:   if (drained) state_next = IDLE;
               else if (!vblank) state_next = PENDING;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_gnt       <= 1'b1;
      err_range      <= 1'b0;
      map_write      <= 1'b0;
      map_write_addr <= '0;
      map_write_data <= '0;
    end else begin
      state     <= state_next;
      map_write <= pop;
      if (accept) last_gnt <= gnt1;
      if (accept && !in_range) err_range <= 1'b1;
      else if (err_clear)      err_range <= 1'b0;
      if (pop) begin
        map_write_addr <= head.addr;
        map_write_data <= {4'd0, head.tile};
      end
    end
  end

endmodule

// File: tb/tb_map_write_scheduler.sv
// Bench for map_write_scheduler: directed scenarios plus randomized traffic
// against a queue-based reference model of arbitration, range check and drain.
module tb_map_write_scheduler;
  import map_sched_pkg::*;

  localparam int DEPTH = 16;
  localparam int CELLS = 1200;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0, reset = 1'b1, vblank = 1'b0, err_clear = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [10:0] req0_addr = '0, req1_addr = '0;
  logic [3:0]  req0_tile = '0, req1_tile = '0;
  logic        req0_ready, req1_ready, map_write, busy, err_range;
  logic [10:0] map_write_addr;
  logic [7:0]  map_write_data;
  logic [4:0]  fifo_count;

  int total = 0, bad = 0;

  // reference model state
  map_req_t mq[$];
  wr_t      exp_w[$], got_w[$];
  bit       m_last = 1'b1, m_wr = 1'b0, m_err = 1'b0;
  bit       exp_r0, exp_r1, obs_r0, obs_r1, obs_mw, obs_busy, obs_err;
  int       obs_cnt;

  always #5 clk = ~clk;

  map_write_scheduler #(.FIFO_DEPTH(DEPTH), .MAP_CELLS(CELLS)) dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_tile(req0_tile), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_tile(req1_tile), .req1_ready(req1_ready),
    .map_write(map_write), .map_write_addr(map_write_addr), .map_write_data(map_write_data),
    .fifo_count(fifo_count), .busy(busy), .err_range(err_range), .err_clear(err_clear)
  );

  always @(posedge clk)
    if (!reset && map_write) got_w.push_back('{map_write_addr, map_write_data});

  // One clock: predict handshakes from the model, advance both, sample after the edge.
  task automatic tick();
    map_req_t e;
    logic [10:0] a;
    logic [3:0] t;
    bit g0, g1, oor, hit, pop, full, acc;
    #1;
    pop  = vblank && mq.size() != 0;
    full = mq.size() == DEPTH;
    g1   = req1_valid && (!req0_valid || !m_last);
    g0   = req0_valid && !g1;
    a    = g1 ? req1_addr : req0_addr;
    t    = g1 ? req1_tile : req0_tile;
    oor  = int'(a) >= CELLS;
    hit  = 1'b0;
`ifdef MAP_WRITE_COALESCE_EN
    if (!oor && mq.size() != 0 && !(pop && mq.size() == 1))
      hit = (mq[mq.size()-1].addr == a);
`endif
    acc    = (g0 || g1) && (oor || hit || !full || pop);
    exp_r0 = g0 && acc;
    exp_r1 = g1 && acc;
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    @(posedge clk);
    if (pop) begin
      e = mq.pop_front();
      exp_w.push_back('{e.addr, {4'd0, e.tile}});
    end
    m_wr = pop;
    if (acc) begin
      m_last = g1;
      if (!oor && hit) begin
        e = mq.pop_back();
        e.tile = t;
        mq.push_back(e);
      end else if (!oor) mq.push_back('{a, t});
    end
    if (acc && oor) m_err = 1'b1;
    else if (err_clear) m_err = 1'b0;
    @(negedge clk);
    obs_cnt  = int'(fifo_count);
    obs_mw   = map_write;
    obs_busy = busy;
    obs_err  = err_range;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; vblank = 1'b0; err_clear = 1'b0;
    if (m_wr) void'(exp_w.pop_back());
    mq.delete();
    m_wr = 1'b0; m_err = 1'b0; m_last = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start();
    do_reset();
    exp_w.delete();
    got_w.delete();
  endtask

  task automatic drain();
    req0_valid = 1'b0; req1_valid = 1'b0; vblank = 1'b1;
    for (int i = 0; i < 40 && mq.size() != 0; i++) tick();
    vblank = 1'b0;
    tick(); tick();
  endtask

  function automatic logic [10:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 11'(1200 + $urandom_range(0, 847));
    return 11'($urandom_range(0, 15));
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if ({map_write, map_write_addr, map_write_data, fifo_count, busy, err_range} !== '0) begin
      bad++;
      $display("FAIL reset_state got wr=%b a=%0d d=%h cnt=%0d busy=%b err=%b want all 0",
               map_write, map_write_addr, map_write_data, fifo_count, busy, err_range);
    end
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 11'd7; req1_valid = 1'b1; req1_addr = 11'd8;
    tick();
    total++;
    if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
      bad++; $display("FAIL reset_rr_favour got r0=%b r1=%b want r0=1 r1=0", obs_r0, obs_r1);
    end
  endtask

  task automatic test_single();
    start();
    req0_valid = 1'b1; req0_addr = 11'd41; req0_tile = 4'd2;
    tick();
    req0_valid = 1'b0;
    total++;
    if (obs_r0 !== 1'b1 || obs_cnt != 1 || obs_mw !== 1'b0) begin
      bad++; $display("FAIL single_push got r=%b cnt=%0d wr=%b want 1 1 0", obs_r0, obs_cnt, obs_mw);
    end
    tick();
    total++;
    if (obs_cnt != 1 || obs_mw !== 1'b0) begin
      bad++; $display("FAIL single_hold got cnt=%0d wr=%b want 1 0", obs_cnt, obs_mw);
    end
    vblank = 1'b1;
    tick();
    total++;
    if (map_write !== 1'b1 || map_write_addr !== 11'd41 || map_write_data !== 8'h02 || obs_cnt != 0) begin
      bad++; $display("FAIL single_write got wr=%b a=%0d d=%h cnt=%0d want 1 41 02 0",
                      map_write, map_write_addr, map_write_data, obs_cnt);
    end
    vblank = 1'b0;
    tick();
    total++;
    if (obs_mw !== 1'b0 || obs_busy !== 1'b0) begin
      bad++; $display("FAIL single_idle got wr=%b busy=%b want 0 0", obs_mw, obs_busy);
    end
  endtask

  task automatic test_round_robin();
    int order[8] = '{10, 20, 11, 21, 12, 22, 13, 23};
    int acc_q[$];
    int p0 = 0, p1 = 0, errs = 0;
    start();
    for (int c = 0; c < 8; c++) begin
      req0_valid = (p0 < 4); req0_addr = 11'(10 + p0); req0_tile = 4'd1;
      req1_valid = (p1 < 4); req1_addr = 11'(20 + p1); req1_tile = 4'd2;
      tick();
      total++;
      if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
        bad++; $display("FAIL rr_ready c=%0d got %b%b want %b%b", c, obs_r0, obs_r1, exp_r0, exp_r1);
      end
      if (obs_r0) begin acc_q.push_back(int'(req0_addr)); p0++; end
      if (obs_r1) begin acc_q.push_back(int'(req1_addr)); p1++; end
    end
    drain();
    for (int i = 0; i < 8; i++)
      if (acc_q.size() != 8 || got_w.size() != 8 || acc_q[i] != order[i] || int'(got_w[i].addr) != order[i])
        errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL rr_order got accepted=%0d writes=%0d bad_slots=%0d want 8 8 0",
                      acc_q.size(), got_w.size(), errs);
    end
  endtask

  task automatic test_full();
    int errs = 0;
    start();
    req0_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req0_addr = 11'(100 + i); req0_tile = 4'(i);
      tick();
    end
    req0_addr = 11'd116; req0_tile = 4'd3;
    tick();
    total++;
    if (obs_r0 !== 1'b0 || obs_cnt != 16) begin
      bad++; $display("FAIL full_block got r=%b cnt=%0d want 0 16", obs_r0, obs_cnt);
    end
    vblank = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (obs_r0 !== 1'b1 || obs_cnt != 16) begin
        bad++; $display("FAIL full_pushpop k=%0d got r=%b cnt=%0d want 1 16", k, obs_r0, obs_cnt);
      end
      req0_addr = req0_addr + 11'd1;
    end
    vblank = 1'b0; req0_valid = 1'b0;
    tick(); tick();
    total++;
    if (got_w.size() != 3 || got_w[0].addr != 11'd100 || got_w[2].addr != 11'd102) begin
      bad++; $display("FAIL full_three_writes got n=%0d want 3 (100..102)", got_w.size());
    end
    drain();
    foreach (exp_w[i]) if (got_w.size() != exp_w.size() || got_w[i] !== exp_w[i]) errs++;
    total++;
    if (errs != 0 || exp_w.size() != 19) begin
      bad++; $display("FAIL full_log got n=%0d model=%0d bad_slots=%0d want 19 19 0",
                      got_w.size(), exp_w.size(), errs);
    end
  endtask

  task automatic test_range();
    start();
    req1_valid = 1'b1; req1_addr = 11'd1200; req1_tile = 4'd3;
    tick();
    req1_valid = 1'b0;
    total++;
    if (obs_r1 !== 1'b1 || obs_cnt != 0 || obs_err !== 1'b1) begin
      bad++; $display("FAIL range_reject got r=%b cnt=%0d err=%b want 1 0 1", obs_r1, obs_cnt, obs_err);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    total++;
    if (obs_err !== 1'b0) begin
      bad++; $display("FAIL range_clear got err=%b want 0", obs_err);
    end
    req0_valid = 1'b1; req0_addr = 11'd2047; err_clear = 1'b1;
    tick();
    req0_valid = 1'b0; err_clear = 1'b0;
    total++;
    if (obs_err !== 1'b1) begin
      bad++; $display("FAIL range_set_wins got err=%b want 1", obs_err);
    end
    req0_valid = 1'b1; req0_addr = 11'd1199; req0_tile = 4'd1;
    tick();
    req0_valid = 1'b0;
    total++;
    if (obs_r0 !== 1'b1 || obs_cnt != 1) begin
      bad++; $display("FAIL range_last_cell got r=%b cnt=%0d want 1 1", obs_r0, obs_cnt);
    end
    drain();
    total++;
    if (got_w.size() != 1 || got_w[0] !== wr_t'({11'd1199, 8'h01})) begin
      bad++; $display("FAIL range_log got n=%0d want one write 1199/01", got_w.size());
    end
  endtask

  task automatic test_drain_reset();
    int errs = 0;
    start();
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req1_addr = 11'(300 + i); req1_tile = 4'(i); tick();
    end
    req1_valid = 1'b0;
    vblank = 1'b1;
    repeat (4) tick();
    vblank = 1'b0;
    tick(); tick();
    total++;
    if (got_w.size() != 4 || obs_cnt != 6 || dut.state !== PENDING) begin
      bad++; $display("FAIL partial_drain got writes=%0d cnt=%0d st=%0d want 4 6 %0d",
                      got_w.size(), obs_cnt, dut.state, PENDING);
    end
    vblank = 1'b1;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if (map_write !== 1'b0 || fifo_count !== 5'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_drain got wr=%b cnt=%0d busy=%b want 0 0 0", map_write, fifo_count, busy);
    end
    do_reset();
    vblank = 1'b1;
    repeat (4) tick();
    vblank = 1'b0;
    foreach (exp_w[i]) if (got_w.size() != exp_w.size() || got_w[i] !== exp_w[i]) errs++;
    total++;
    if (got_w.size() != 5 || errs != 0) begin
      bad++; $display("FAIL reset_drop_log got n=%0d bad_slots=%0d want 5 0", got_w.size(), errs);
    end
  endtask

  task automatic test_coalesce();
    wr_t co_exp[$];
    int  want_cnt, errs = 0;
`ifdef MAP_WRITE_COALESCE_EN
    want_cnt = 1;
    co_exp.push_back('{11'd5, 8'h02});
`else
    want_cnt = 2;
    co_exp.push_back('{11'd5, 8'h01});
    co_exp.push_back('{11'd5, 8'h02});
`endif
    start();
    req0_valid = 1'b1; req0_addr = 11'd5; req0_tile = 4'd1;
    tick();
    req0_tile = 4'd2;
    tick();
    req0_valid = 1'b0;
    total++;
    if (obs_cnt != want_cnt || obs_r0 !== 1'b1) begin
      bad++; $display("FAIL same_cell_count got cnt=%0d r=%b want %0d 1", obs_cnt, obs_r0, want_cnt);
    end
    drain();
    foreach (co_exp[i]) if (got_w.size() != co_exp.size() || got_w[i] !== co_exp[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL same_cell_log got n=%0d bad_slots=%0d want %0d 0", got_w.size(), errs, co_exp.size());
    end
  endtask

  task automatic test_random();
    int errs = 0;
    bit exp_busy;
    start();
    for (int c = 0; c < 600; c++) begin
      req0_valid = ($urandom_range(0, 2) != 0); req0_addr = rnd_addr(); req0_tile = 4'($urandom_range(0, 15));
      req1_valid = ($urandom_range(0, 2) != 0); req1_addr = rnd_addr(); req1_tile = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) vblank = !vblank;
      err_clear = ($urandom_range(0, 15) == 0);
      tick();
      exp_busy = (mq.size() != 0) || m_wr;
      total++;
      if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1 || obs_cnt != mq.size() ||
          obs_err !== m_err || obs_busy !== exp_busy || obs_mw !== m_wr) begin
        bad++;
        $display("FAIL rand c=%0d got r=%b%b cnt=%0d err=%b busy=%b wr=%b want r=%b%b cnt=%0d err=%b busy=%b wr=%b",
                 c, obs_r0, obs_r1, obs_cnt, obs_err, obs_busy, obs_mw,
                 exp_r0, exp_r1, mq.size(), m_err, exp_busy, m_wr);
      end
    end
    err_clear = 1'b0;
    drain();
    foreach (exp_w[i]) if (got_w.size() != exp_w.size() || got_w[i] !== exp_w[i]) errs++;
    total++;
    if (got_w.size() != exp_w.size() || errs != 0) begin
      bad++; $display("FAIL rand_log got n=%0d want n=%0d bad_slots=%0d", got_w.size(), exp_w.size(), errs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_range();
    test_drain_reset();
    test_coalesce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
